// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 320x240 12-bit frame buffer with 2x2 pixel replication.
// A built-in colour-bar pattern replaces frame buffer data when fb_enable is low.
module vga_frame_reader #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fb_enable,
  input  logic [11:0] dataOut,
  output logic [16:0] addrb,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] TickLast   = 4'(CLK_DIV - 1);
  localparam logic [9:0] HLast      = 10'(H_TOT - 1);
  localparam logic [9:0] VLast      = 10'(V_TOT - 1);
  localparam logic [9:0] HVis       = 10'(H_VIS);
  localparam logic [9:0] VVis       = 10'(V_VIS);
  localparam logic [9:0] HSyncStart = 10'(H_VIS + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VIS + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC);

  logic [3:0]  tick_q, tick_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        pix_tick;
  logic        active;
  logic        wrap;
  logic [8:0]  fb_x;
  logic [7:0]  fb_y;
  logic [16:0] addr_full;
  logic [11:0] bar_rgb;
  logic [11:0] rgb_d;

  logic        hsync_q, vsync_q, video_on_q, vblank_q, frame_start_q;
  logic [11:0] rgb_q;

  // Pixel-rate timing counters
  always_comb begin
    pix_tick = (tick_q == TickLast);
    tick_d   = pix_tick ? 4'd0 : tick_q + 4'd1;
    h_d      = h_q;
    v_d      = v_q;
    wrap     = pix_tick && (h_q == HLast) && (v_q == VLast);
    if (pix_tick) begin
      if (h_q == HLast) begin
        h_d = 10'd0;
        v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // y*320 + x as two shifts and adds
  always_comb begin
    active    = (h_q < HVis) && (v_q < VVis);
    fb_x      = h_q[9:1];
    fb_y      = v_q[8:1];
    addr_full = 17'({fb_y, 8'b0}) + 17'({fb_y, 6'b0}) + 17'(fb_x);
    addrb     = active ? addr_full : 17'd0;
  end

  // Eight 80-pixel-wide colour bars
  always_comb begin
    if      (h_q < 10'd80)  bar_rgb = 12'hFFF;
    else if (h_q < 10'd160) bar_rgb = 12'hFF0;
    else if (h_q < 10'd240) bar_rgb = 12'h0FF;
    else if (h_q < 10'd320) bar_rgb = 12'h0F0;
    else if (h_q < 10'd400) bar_rgb = 12'hF0F;
    else if (h_q < 10'd480) bar_rgb = 12'hF00;
    else if (h_q < 10'd560) bar_rgb = 12'h00F;
    else                    bar_rgb = 12'h000;
  end

  always_comb begin
    rgb_d = 12'h000;
    if (active) begin
      rgb_d = fb_enable ? dataOut : bar_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q        <= 4'd0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
      video_on_q    <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= wrap;
      // Output stage lags the counters by one pixel, keeping sync and colour aligned
      if (pix_tick) begin
        hsync_q    <= !((h_q >= HSyncStart) && (h_q < HSyncEnd));
        vsync_q    <= !((v_q >= VSyncStart) && (v_q < VSyncEnd));
        video_on_q <= active;
        vblank_q   <= (v_q >= VVis);
        rgb_q      <= rgb_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign video_on    = video_on_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule
